// File: rtl/traffic_light_safety_monitor.sv
// Traffic light safety monitor.
// Sits between the light controller and the lamp drivers. Every cycle it
// checks the requested light vectors for illegal encodings and conflicting
// greens, passes clean requests to the lamps, and falls back to a flashing
// fail-safe mode when a fault persists. Leaving the fail-safe mode, and
// coming out of reset, both go through an all-red clearance interval.
module traffic_light_safety_monitor #(
   parameter int FAULT_FILT = 2,
   parameter int FLASH_DIV  = 4,
   parameter int ALLRED_CYC = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] light_M1,
   input  logic [2:0] light_M2,
   input  logic [2:0] light_MT,
   input  logic [2:0] light_S,
   input  logic       clr_fault,
   output logic [2:0] lamp_M1,
   output logic [2:0] lamp_M2,
   output logic [2:0] lamp_MT,
   output logic [2:0] lamp_S,
   output logic       fault,
   output logic [1:0] fault_code
);

   localparam int BW_BAD   = $clog2(FAULT_FILT) + 1;
   localparam int BW_FLASH = $clog2(FLASH_DIV) + 1;
   localparam int BW_ALLR  = $clog2(ALLRED_CYC) + 1;

   localparam logic [2:0] LAMP_RED = 3'b100;
   localparam logic [2:0] LAMP_YEL = 3'b010;
   localparam logic [2:0] LAMP_OFF = 3'b000;

   typedef enum logic [1:0] {
      NORMAL  = 2'd0,
      SUSPECT = 2'd1,
      FLASH   = 2'd2,
      ALL_RED = 2'd3
   } state_t;

   state_t                r_state;
   logic [BW_BAD-1:0]     r_badCnt;
   logic [BW_FLASH-1:0]   r_flashCnt;
   logic [BW_ALLR-1:0]    r_allredCnt;
   logic                  r_phaseOn;
   logic [2:0]            r_lampM1;
   logic [2:0]            r_lampM2;
   logic [2:0]            r_lampMT;
   logic [2:0]            r_lampS;
   logic                  r_fault;
   logic [1:0]            r_faultCode;

   logic                  w_encErr;
   logic                  w_conflict;
   logic                  w_inBad;
   logic [BW_BAD:0]       w_badInc;
   logic                  w_goFlash;

   function automatic logic isLegal(input logic [2:0] v);
      return (v == 3'b100) || (v == 3'b010) || (v == 3'b001);
   endfunction

   function automatic logic isNonRed(input logic [2:0] v);
      return (v == 3'b010) || (v == 3'b001);
   endfunction

   // Input health: a vector outside the one-hot set, or two crossing
   // movements showing anything other than red at the same time.
   assign w_encErr = !isLegal(light_M1) || !isLegal(light_M2) ||
                     !isLegal(light_MT) || !isLegal(light_S);
   assign w_conflict = (isNonRed(light_S) &&
                        (isNonRed(light_M1) || isNonRed(light_M2) || isNonRed(light_MT))) ||
                       (isNonRed(light_M2) && isNonRed(light_MT));
   assign w_inBad = w_encErr | w_conflict;

   // Trip decision: a bad cycle during clearance trips at once, otherwise
   // the fault must last FAULT_FILT consecutive cycles.
   assign w_badInc  = {1'b0, r_badCnt} + (BW_BAD + 1)'(1);
   assign w_goFlash = w_inBad &&
                      ((r_state == ALL_RED) ||
                       ((r_state == NORMAL) && (FAULT_FILT == 1)) ||
                       ((r_state == SUSPECT) && (w_badInc >= (BW_BAD + 1)'(FAULT_FILT))));

   assign lamp_M1    = r_lampM1;
   assign lamp_M2    = r_lampM2;
   assign lamp_MT    = r_lampMT;
   assign lamp_S     = r_lampS;
   assign fault      = r_fault;
   assign fault_code = r_faultCode;

   // Monitor state machine with registered lamp drives and fault reporting.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ALL_RED;
         r_badCnt    <= '0;
         r_flashCnt  <= '0;
         r_allredCnt <= '0;
         r_phaseOn   <= 1'b0;
         r_lampM1    <= LAMP_RED;
         r_lampM2    <= LAMP_RED;
         r_lampMT    <= LAMP_RED;
         r_lampS     <= LAMP_RED;
         r_fault     <= 1'b0;
         r_faultCode <= 2'b00;
      end else if (w_goFlash) begin
         r_state     <= FLASH;
         r_badCnt    <= BW_BAD'(FAULT_FILT);
         r_flashCnt  <= '0;
         r_phaseOn   <= 1'b1;
         r_fault     <= 1'b1;
         r_faultCode <= {w_conflict, w_encErr};
         r_lampM1    <= LAMP_YEL;
         r_lampM2    <= LAMP_YEL;
         r_lampMT    <= LAMP_YEL;
         r_lampS     <= LAMP_RED;
      end else begin
         case (r_state)
            NORMAL: begin
               if (w_inBad) begin
                  r_state  <= SUSPECT;
                  r_badCnt <= BW_BAD'(1);
                  r_lampM1 <= LAMP_RED;
                  r_lampM2 <= LAMP_RED;
                  r_lampMT <= LAMP_RED;
                  r_lampS  <= LAMP_RED;
               end else begin
                  r_lampM1 <= light_M1;
                  r_lampM2 <= light_M2;
                  r_lampMT <= light_MT;
                  r_lampS  <= light_S;
               end
            end
            SUSPECT: begin
               if (w_inBad) begin
                  r_badCnt <= w_badInc[BW_BAD-1:0];
                  r_lampM1 <= LAMP_RED;
                  r_lampM2 <= LAMP_RED;
                  r_lampMT <= LAMP_RED;
                  r_lampS  <= LAMP_RED;
               end else begin
                  r_state  <= NORMAL;
                  r_badCnt <= '0;
                  r_lampM1 <= light_M1;
                  r_lampM2 <= light_M2;
                  r_lampMT <= light_MT;
                  r_lampS  <= light_S;
               end
            end
            FLASH: begin
               if (clr_fault && !w_inBad) begin
                  r_state     <= ALL_RED;
                  r_allredCnt <= '0;
                  r_fault     <= 1'b0;
                  r_lampM1    <= LAMP_RED;
                  r_lampM2    <= LAMP_RED;
                  r_lampMT    <= LAMP_RED;
                  r_lampS     <= LAMP_RED;
               end else if (r_flashCnt == BW_FLASH'(FLASH_DIV - 1)) begin
                  r_flashCnt <= '0;
                  r_phaseOn  <= !r_phaseOn;
                  r_lampM1   <= r_phaseOn ? LAMP_OFF : LAMP_YEL;
                  r_lampM2   <= r_phaseOn ? LAMP_OFF : LAMP_YEL;
                  r_lampMT   <= r_phaseOn ? LAMP_OFF : LAMP_YEL;
                  r_lampS    <= r_phaseOn ? LAMP_OFF : LAMP_RED;
               end else begin
                  r_flashCnt <= r_flashCnt + BW_FLASH'(1);
                  r_lampM1   <= r_phaseOn ? LAMP_YEL : LAMP_OFF;
                  r_lampM2   <= r_phaseOn ? LAMP_YEL : LAMP_OFF;
                  r_lampMT   <= r_phaseOn ? LAMP_YEL : LAMP_OFF;
                  r_lampS    <= r_phaseOn ? LAMP_RED : LAMP_OFF;
               end
            end
            ALL_RED: begin
               r_lampM1 <= LAMP_RED;
               r_lampM2 <= LAMP_RED;
               r_lampMT <= LAMP_RED;
               r_lampS  <= LAMP_RED;
               if (r_allredCnt == BW_ALLR'(ALLRED_CYC - 1)) begin
                  r_state     <= NORMAL;
                  r_badCnt    <= '0;
                  r_faultCode <= 2'b00;
               end else begin
                  r_allredCnt <= r_allredCnt + BW_ALLR'(1);
               end
            end
            default: begin
               r_state     <= ALL_RED;
               r_allredCnt <= '0;
               r_lampM1    <= LAMP_RED;
               r_lampM2    <= LAMP_RED;
               r_lampMT    <= LAMP_RED;
               r_lampS     <= LAMP_RED;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_traffic_light_safety_monitor.sv
// Testbench for the traffic light safety monitor.
// Directed scenarios followed by randomized traffic, all compared every
// cycle against a behavioural model of the monitor's rules.
module tb_traffic_light_safety_monitor;

   localparam int FAULT_FILT = 2;
   localparam int FLASH_DIV  = 4;
   localparam int ALLRED_CYC = 4;

   localparam logic [11:0] ALL_RED_LAMPS = 12'b100_100_100_100;
   localparam logic [11:0] FLASH_ON      = 12'b010_010_010_100;
   localparam logic [11:0] FLASH_OFF     = 12'b000_000_000_000;

   logic       clk;
   logic       rst;
   logic [2:0] light_M1;
   logic [2:0] light_M2;
   logic [2:0] light_MT;
   logic [2:0] light_S;
   logic       clr_fault;
   logic [2:0] lamp_M1;
   logic [2:0] lamp_M2;
   logic [2:0] lamp_MT;
   logic [2:0] lamp_S;
   logic       fault;
   logic [1:0] fault_code;

   int nChecks = 0;
   int nPass   = 0;
   int cycle   = 0;

   // Reference model state, expressed as elapsed-time quantities.
   bit          mFlashing;
   int          mFlashAge;
   int          mClearDone;
   int          mBadRun;
   logic [11:0] mLamps;
   logic        mFault;
   logic [1:0]  mCode;

   traffic_light_safety_monitor #(
      .FAULT_FILT(FAULT_FILT),
      .FLASH_DIV (FLASH_DIV),
      .ALLRED_CYC(ALLRED_CYC)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .light_M1  (light_M1),
      .light_M2  (light_M2),
      .light_MT  (light_MT),
      .light_S   (light_S),
      .clr_fault (clr_fault),
      .lamp_M1   (lamp_M1),
      .lamp_M2   (lamp_M2),
      .lamp_MT   (lamp_MT),
      .lamp_S    (lamp_S),
      .fault     (fault),
      .fault_code(fault_code)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic bit legal(input logic [2:0] v);
      return (v == 3'b100) || (v == 3'b010) || (v == 3'b001);
   endfunction

   function automatic bit nonRed(input logic [2:0] v);
      return (v == 3'b010) || (v == 3'b001);
   endfunction

   function automatic logic [2:0] randLegal();
      case ($urandom_range(0, 2))
         0:       return 3'b100;
         1:       return 3'b010;
         default: return 3'b001;
      endcase
   endfunction

   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      nChecks++;
      if (observed === expected) nPass++;
      else $display("[TB] FAIL %s cycle %0d: got %b expected %b", tag, cycle, observed, expected);
   endtask

   task automatic modelReset();
      mFlashing  = 0;
      mFlashAge  = 0;
      mClearDone = 0;
      mBadRun    = 0;
      mLamps     = ALL_RED_LAMPS;
      mFault     = 1'b0;
      mCode      = 2'b00;
   endtask

   // One clock edge of the monitor's rules, given the inputs seen on it.
   task automatic modelStep(input logic [2:0] m1, input logic [2:0] m2, input logic [2:0] mt,
                            input logic [2:0] s, input logic clr);
      bit enc, conf, bad;
      enc  = !legal(m1) || !legal(m2) || !legal(mt) || !legal(s);
      conf = (nonRed(s) && (nonRed(m1) || nonRed(m2) || nonRed(mt))) || (nonRed(m2) && nonRed(mt));
      bad  = enc || conf;
      if (mFlashing) begin
         if (clr && !bad) begin
            mFlashing  = 0;
            mClearDone = 0;
            mFault     = 1'b0;
            mLamps     = ALL_RED_LAMPS;
         end else begin
            mFlashAge++;
            mLamps = (((mFlashAge / FLASH_DIV) % 2) == 0) ? FLASH_ON : FLASH_OFF;
         end
      end else if (bad && (mClearDone >= 0 || mBadRun + 1 >= FAULT_FILT)) begin
         mFlashing  = 1;
         mFlashAge  = 0;
         mClearDone = -1;
         mBadRun    = 0;
         mFault     = 1'b1;
         mCode      = {conf, enc};
         mLamps     = FLASH_ON;
      end else if (mClearDone >= 0) begin
         mClearDone++;
         mLamps = ALL_RED_LAMPS;
         if (mClearDone == ALLRED_CYC) begin
            mClearDone = -1;
            mCode      = 2'b00;
         end
      end else if (bad) begin
         mBadRun++;
         mLamps = ALL_RED_LAMPS;
      end else begin
         mBadRun = 0;
         mLamps  = {m1, m2, mt, s};
      end
   endtask

   task automatic compareAll();
      checkOutput("lamps", {4'b0, lamp_M1, lamp_M2, lamp_MT, lamp_S}, {4'b0, mLamps});
      checkOutput("fault", {15'b0, fault}, {15'b0, mFault});
      checkOutput("fault_code", {14'b0, fault_code}, {14'b0, mCode});
   endtask

   // Drive one cycle of inputs, advance the model, and check after the edge.
   task automatic applyStimulus(input logic [2:0] m1, input logic [2:0] m2, input logic [2:0] mt,
                                input logic [2:0] s, input logic clr);
      light_M1  = m1;
      light_M2  = m2;
      light_MT  = mt;
      light_S   = s;
      clr_fault = clr;
      modelStep(m1, m2, mt, s, clr);
      @(posedge clk);
      #1;
      cycle++;
      compareAll();
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic pulseReset();
      #3;
      rst = 1'b0;
      #1;
      modelReset();
      checkOutput("async_rst_lamps", {4'b0, lamp_M1, lamp_M2, lamp_MT, lamp_S}, {4'b0, ALL_RED_LAMPS});
      checkOutput("async_rst_fault", {14'b0, fault, fault_code[0]}, 16'h0000);
      checkOutput("async_rst_code", {14'b0, fault_code}, 16'h0000);
      #3;
      rst = 1'b1;
   endtask

   task automatic repeatClean(input int n, input logic clr);
      for (int i = 0; i < n; i++) applyStimulus(3'b001, 3'b001, 3'b100, 3'b100, clr);
   endtask

   initial begin
      logic [2:0] r1, r2, rt, rs;
      rst       = 1'b0;
      light_M1  = 3'b001;
      light_M2  = 3'b001;
      light_MT  = 3'b100;
      light_S   = 3'b100;
      clr_fault = 1'b0;
      modelReset();
      @(posedge clk);
      #1;
      compareAll();
      #3;
      rst = 1'b1;

      // Power-up clearance, then pass-through
      repeatClean(6, 1'b0);
      // Single-cycle side glitch
      applyStimulus(3'b001, 3'b100, 3'b100, 3'b001, 1'b0);
      repeatClean(2, 1'b0);
      // Persistent conflict trips into flashing
      applyStimulus(3'b001, 3'b100, 3'b100, 3'b001, 1'b0);
      applyStimulus(3'b001, 3'b100, 3'b100, 3'b001, 1'b0);
      repeatClean(10, 1'b0);
      // Clear with a bad input is ignored, then a clean clear
      applyStimulus(3'b001, 3'b011, 3'b100, 3'b100, 1'b1);
      repeatClean(1, 1'b1);
      repeatClean(6, 1'b0);
      // Encoding error fault
      applyStimulus(3'b001, 3'b011, 3'b100, 3'b100, 1'b0);
      applyStimulus(3'b001, 3'b011, 3'b100, 3'b100, 1'b0);
      repeatClean(1, 1'b1);
      repeatClean(2, 1'b0);
      // Conflict during clearance goes straight back to flashing
      applyStimulus(3'b100, 3'b001, 3'b001, 3'b100, 1'b0);
      repeatClean(1, 1'b1);
      repeatClean(6, 1'b0);
      // Both fault kinds at once
      applyStimulus(3'b001, 3'b011, 3'b100, 3'b001, 1'b0);
      applyStimulus(3'b001, 3'b011, 3'b100, 3'b001, 1'b0);
      // Run into the off phase, then reset asynchronously
      repeatClean(5, 1'b0);
      checkOutput("flash_off_phase", {4'b0, lamp_M1, lamp_M2, lamp_MT, lamp_S}, {4'b0, FLASH_OFF});
      pulseReset();
      repeatClean(6, 1'b0);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 15) < 12) begin
            if ($urandom_range(0, 3) == 0) begin
               r1 = 3'b100; r2 = 3'b100; rt = 3'b100;
               rs = ($urandom_range(0, 1) == 0) ? 3'b010 : 3'b001;
            end else begin
               rs = 3'b100;
               r1 = randLegal();
               if ($urandom_range(0, 1) == 0) begin
                  r2 = randLegal(); rt = 3'b100;
               end else begin
                  rt = randLegal(); r2 = 3'b100;
               end
            end
         end else begin
            r1 = 3'($urandom_range(0, 7));
            r2 = 3'($urandom_range(0, 7));
            rt = 3'($urandom_range(0, 7));
            rs = 3'($urandom_range(0, 7));
         end
         applyStimulus(r1, r2, rt, rs, $urandom_range(0, 3) == 0);
      end

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
